core2_cpu_oci_trace_monitor: RTL and testbench

CORE2_CPU_OCI_TRACE_MONITOR -- requirements
Module: core2_cpu_oci_trace_monitor

---
 rtl/core2_oci_pkg.sv | 17 +
 rtl/core2_oci_trace_fifo.sv | 66 ++++++
 rtl/core2_cpu_oci_trace_monitor.sv | 115 +++++++++++
 tb/tb_core2_cpu_oci_trace_monitor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/core2_oci_pkg.sv
// Shared definitions for the OCI trace monitor.
// Holds the monitor FSM state type and the default widths and limits
// that the top-level parameters pick up.
package core2_oci_pkg;

    localparam int DCT_W_DEF     = 30;
    localparam int CNT_W_DEF     = 4;
    localparam int DEPTH_DEF     = 16;
    localparam int MAX_COUNT_DEF = 15;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENDED = 2'd2
    } mon_state_t;

endpackage

// File: rtl/core2_oci_trace_fifo.sv
// Show-ahead synchronous FIFO holding captured trace words.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (pointers/level only)
//   push, pop      - write / read strobes; the caller only asserts them when legal
//                    (push when not full or popping, pop when not empty)
//   wr_data        - word to store
//   rd_data        - head word, valid whenever empty is low
//   empty, full    - occupancy flags
//   level          - number of stored words, 0..DEPTH
module core2_oci_trace_fifo
    import core2_oci_pkg::*;
#(
    parameter int W     = DCT_W_DEF + CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset; stale contents are hidden behind empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // When full with push and pop together, wr_ptr == rd_ptr: the head is read
    // combinationally before the edge overwrites that slot, so order holds.
    assign rd_data = mem[rd_ptr];
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/core2_cpu_oci_trace_monitor.sv
// OCI debug-capture-trace monitor.
// Captures qualified DCT words into a show-ahead FIFO until a test-ending
// request, then drains the FIFO and reports that the test has ended.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   dct_valid/buffer/count     - trace word from OCI; count 0 words are discarded
//   test_ending                - stop capture and drain (honoured in RUN only)
//   rd_ready/valid/buffer/count- consumer handshake on the FIFO head
//   fill_level                 - words stored
//   overflow_cnt               - words dropped on a full FIFO, saturating
//   count_error                - sticky: a captured word had count > MAX_COUNT
//   test_has_ended             - capture stopped and FIFO drained
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_RUN   | capturing dct words, consumer may pop
// ST_DRAIN | capture stopped, waiting for the FIFO to empty
// ST_ENDED | FIFO drained, held until reset
module core2_cpu_oci_trace_monitor
    import core2_oci_pkg::*;
#(
    parameter int DCT_W     = DCT_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int MAX_COUNT = MAX_COUNT_DEF,
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dct_valid,
    input  logic [DCT_W-1:0]  dct_buffer,
    input  logic [CNT_W-1:0]  dct_count,
    input  logic              test_ending,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DCT_W-1:0]  rd_buffer,
    output logic [CNT_W-1:0]  rd_count,
    output logic [LVL_W-1:0]  fill_level,
    output logic [15:0]       overflow_cnt,
    output logic              count_error,
    output logic              test_has_ended
);

    // One extra bit so MAX_COUNT == 2**CNT_W-1 compares cleanly.
    localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_COUNT);

    mon_state_t state;
    mon_state_t state_nxt;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic want_push;
    logic push;
    logic drop;
    logic count_over;

    assign pop        = !fifo_empty && rd_ready;
    assign want_push  = (state == ST_RUN) && dct_valid && (dct_count != '0);
    assign push       = want_push && (!fifo_full || pop);
    assign drop       = want_push && fifo_full && !pop;
    assign count_over = ({1'b0, dct_count} > MAX_C);

    core2_oci_trace_fifo #(
        .W     (DCT_W + CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data ({dct_count, dct_buffer}),
        .rd_data ({rd_count, rd_buffer}),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fill_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (test_ending) state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_empty)  state_nxt = ST_ENDED;
            ST_ENDED: state_nxt = ST_ENDED;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_cnt <= '0;
            count_error  <= 1'b0;
        end else begin
            if (drop && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
            // The word is stored as-is; only the flag records the bad count.
            if (push && count_over) begin
                count_error <= 1'b1;
            end
        end
    end

    assign rd_valid       = !fifo_empty;
    assign test_has_ended = (state == ST_ENDED);

endmodule

// File: tb/tb_core2_cpu_oci_trace_monitor.sv
// Directed bench for core2_cpu_oci_trace_monitor with a queue scoreboard.
// A second instance built with MAX_COUNT=7 shares all stimulus.
module tb_core2_cpu_oci_trace_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dct_valid = 1'b0;
    logic [29:0] dct_buffer = '0;
    logic [3:0]  dct_count = '0;
    logic        test_ending = 1'b0;
    logic        rd_ready = 1'b0;

    logic        rd_valid, rd_valid7;
    logic [29:0] rd_buffer, rd_buffer7;
    logic [3:0]  rd_count, rd_count7;
    logic [4:0]  fill_level, fill_level7;
    logic [15:0] overflow_cnt, overflow_cnt7;
    logic        count_error, count_error7;
    logic        test_has_ended, test_has_ended7;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [33:0] q[$];
    int          m_state = 0;
    int          m_ovf   = 0;
    bit          m_cerr7 = 1'b0;

    always #5 clk = ~clk;

    core2_cpu_oci_trace_monitor dut (
        .clk            (clk),
        .reset          (reset),
        .dct_valid      (dct_valid),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_buffer      (rd_buffer),
        .rd_count       (rd_count),
        .fill_level     (fill_level),
        .overflow_cnt   (overflow_cnt),
        .count_error    (count_error),
        .test_has_ended (test_has_ended)
    );

    core2_cpu_oci_trace_monitor #(.MAX_COUNT(7)) dut7 (
        .clk            (clk),
        .reset          (reset),
        .dct_valid      (dct_valid),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid7),
        .rd_buffer      (rd_buffer7),
        .rd_count       (rd_count7),
        .fill_level     (fill_level7),
        .overflow_cnt   (overflow_cnt7),
        .count_error    (count_error7),
        .test_has_ended (test_has_ended7)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic post_checks();
        chk("fill_level", fill_level, q.size());
        chk("fill_level7", fill_level7, q.size());
        chk("overflow_cnt", overflow_cnt, m_ovf);
        chk("overflow_cnt7", overflow_cnt7, m_ovf);
        chk("test_has_ended", test_has_ended, m_state == 2);
        chk("test_has_ended7", test_has_ended7, m_state == 2);
        chk("count_error", count_error, 1'b0);
        chk("count_error7", count_error7, m_cerr7);
    endtask

    // One clock: drive inputs, check the head against the scoreboard before
    // the edge, advance the model, then check state after the edge.
    task automatic cycle(input bit v, input logic [29:0] b, input logic [3:0] c,
                         input bit te, input bit rr);
        bit pop_m, push_m, drop_m;
        int nst;
        dct_valid   = v;
        dct_buffer  = b;
        dct_count   = c;
        test_ending = te;
        rd_ready    = rr;
        #1;
        chk("rd_valid", rd_valid, q.size() != 0);
        chk("rd_valid7", rd_valid7, q.size() != 0);
        if (q.size() != 0) begin
            chk("rd_buffer", rd_buffer, q[0][29:0]);
            chk("rd_count", rd_count, q[0][33:30]);
            chk("rd_word7", {rd_count7, rd_buffer7}, q[0]);
        end
        pop_m  = (q.size() != 0) && rr;
        push_m = (m_state == 0) && v && (c != 0) && ((q.size() < 16) || pop_m);
        drop_m = (m_state == 0) && v && (c != 0) && !push_m;
        nst = m_state;
        if (m_state == 0 && te) nst = 1;
        else if (m_state == 1 && q.size() == 0) nst = 2;
        @(posedge clk);
        #1;
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back({c, b});
        if (drop_m && m_ovf < 65535) m_ovf++;
        if (push_m && c > 4'd7) m_cerr7 = 1'b1;
        m_state = nst;
        post_checks();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dct_valid = 1'b0; dct_count = '0; dct_buffer = '0;
        test_ending = 1'b0; rd_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_state = 0;
        m_ovf   = 0;
        m_cerr7 = 1'b0;
        chk("rst_rd_valid", rd_valid, 1'b0);
        post_checks();
    endtask

    initial begin
        do_reset();

        // three words read back in order, 1-cycle latency
        cycle(1, 30'h0AA0001, 4'd1, 0, 1);
        chk("first_latency", rd_valid, 1'b1);
        cycle(1, 30'h0AA0002, 4'd2, 0, 1);
        cycle(1, 30'h0AA0003, 4'd3, 0, 1);
        repeat (3) cycle(0, '0, '0, 0, 1);
        chk("drained_3", fill_level, 5'd0);

        // fill to 16, then 5 drops; pointers wrap past the earlier 3 words
        for (int i = 0; i < 16; i++) cycle(1, 30'h100 + 30'(i), 4'((i % 15) + 1), 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 30'h200 + 30'(i), 4'd5, 0, 0);
        chk("full_level", fill_level, 5'd16);
        chk("ovf_5", overflow_cnt, 16'd5);
        chk("head_kept", rd_buffer, 30'h100);

        // push+pop on a full FIFO
        cycle(1, 30'h3FFFFFFF, 4'd9, 0, 1);
        chk("full_pp_level", fill_level, 5'd16);
        chk("full_pp_ovf", overflow_cnt, 16'd5);
        repeat (15) cycle(0, '0, '0, 0, 1);
        chk("new_word_last", rd_buffer, 30'h3FFFFFFF);
        cycle(0, '0, '0, 0, 1);

        // count 0 discarded, 15 stored, 9 flags only the MAX_COUNT=7 build
        cycle(1, 30'h5, 4'd0, 0, 0);
        chk("zero_discard", fill_level, 5'd0);
        cycle(1, 30'h6, 4'd15, 0, 0);
        chk("cerr7_after15", count_error7, 1'b1);
        cycle(1, 30'h7, 4'd9, 0, 0);
        chk("cerr7_after9", count_error7, 1'b1);
        chk("cerr15_after9", count_error, 1'b0);
        repeat (3) cycle(0, '0, '0, 0, 1);

        // test_ending with 4 words, later dct_valid ignored, drain
        for (int i = 0; i < 4; i++) cycle(1, 30'h400 + 30'(i), 4'd2, 0, 0);
        cycle(0, '0, '0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 30'h500, 4'd3, 0, 0);
        chk("drain_ignores", fill_level, 5'd4);
        repeat (4) cycle(0, '0, '0, 0, 1);
        chk("after_last_pop", test_has_ended, 1'b0);
        cycle(0, '0, '0, 0, 1);
        chk("ended", test_has_ended, 1'b1);
        repeat (3) cycle(1, 30'h501, 4'd3, 1, 1);
        chk("ended_sticky", test_has_ended, 1'b1);
        chk("ended_no_push", fill_level, 5'd0);

        // reset during DRAIN with 2 words (second captured with test_ending)
        do_reset();
        cycle(1, 30'h600, 4'd4, 0, 0);
        cycle(1, 30'h601, 4'd5, 1, 0);
        cycle(1, 30'h602, 4'd6, 0, 0);
        chk("drain_2", fill_level, 5'd2);
        do_reset();
        chk("rst_fill", fill_level, 5'd0);
        cycle(1, 30'h700, 4'd1, 0, 0);
        chk("run_after_rst", fill_level, 5'd1);
        cycle(0, '0, '0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
